// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster constants, pixel-word field layout and the sync/de bundle
// shared by the scan controller and its delay line.
package vga_timing_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_H_TOT = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOT = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int PIX_W = 12;
    localparam int R_HI  = 11;
    localparam int R_LO  = 8;
    localparam int G_HI  = 7;
    localparam int G_LO  = 4;
    localparam int B_HI  = 3;
    localparam int B_LO  = 0;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    // Blanked, sync deasserted: what the pins show before any real coordinate arrives.
    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

    function automatic logic [3:0] pix_r(input logic [PIX_W-1:0] p);
        return p[R_HI:R_LO];
    endfunction

    function automatic logic [3:0] pix_g(input logic [PIX_W-1:0] p);
        return p[G_HI:G_LO];
    endfunction

    function automatic logic [3:0] pix_b(input logic [PIX_W-1:0] p);
        return p[B_HI:B_LO];
    endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Scan bus between the raster controller (master) and the renderers/VGA pins (slave).
interface vga_scan_ctrl_if;
    logic [11:0] vga_in;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        active;
    logic        pix_tick;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  vga_in,
        output col, row, active, pix_tick, hs, vs, r, g, b, frame_start, frame_cnt
    );

    modport slave (
        output vga_in,
        input  col, row, active, pix_tick, hs, vs, r, g, b, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_sync_delay.sv
// Pixel-tick shift register that carries {hs, vs, de} across the renderer latency;
// resets to the idle (blanked) bundle.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  sync_t d,
    output sync_t q
);

    sync_t dly_p [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) dly_p[i] <= SYNC_IDLE;
        end else if (en) begin
            dly_p[0] <= d;
            for (int i = 1; i < STAGES; i++) dly_p[i] <= dly_p[i-1];
        end
    end

    assign q = dly_p[STAGES-1];

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan master: pixel-rate divider, h/v counters, frame pacing, and VGA pins
// whose sync/blanking lag the presented coordinate by LEAD pixel ticks.
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int LEAD    = 1,
    parameter int H_VIS   = VGA_H_VIS,
    parameter int H_FP    = VGA_H_FP,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BP    = VGA_H_BP,
    parameter int V_VIS   = VGA_V_VIS,
    parameter int V_FP    = VGA_V_FP,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BP    = VGA_V_BP
) (
    input logic             clk,
    input logic             rst_n,
    vga_scan_ctrl_if.master bus
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             pix_tick;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             active;
    logic             at_end;
    logic             frame_start;
    logic [15:0]      frame_cnt;
    sync_t            raw_nxt;
    sync_t            sync_dly;
    logic             hs_q;
    logic             vs_q;
    logic [PIX_W-1:0] rgb_q;

    assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
    assign at_end  = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Raw sync/de are taken from the coordinate about to be presented, so the
    // LEAD-deep delay plus the pin register line up exactly LEAD ticks behind col/row.
    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end
        raw_nxt.hs = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
        raw_nxt.vs = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
        raw_nxt.de = (h_nxt < H_VIS_L) && (v_nxt < V_VIS_L);
    end

    // Stage p0: divider, raster counters, frame pacing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            pix_tick    <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            active      <= 1'b1;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            div         <= div_nxt;
            pix_tick    <= (div_nxt == DIV_LAST);
            frame_start <= (div_nxt == DIV_LAST) && at_end;
            if (pix_tick) begin
                h_cnt  <= h_nxt;
                v_cnt  <= v_nxt;
                active <= raw_nxt.de;
                if (at_end) frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    vga_sync_delay #(.STAGES(LEAD)) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_tick),
        .d     (raw_nxt),
        .q     (sync_dly)
    );

    // Stage p1: pin register; colour is forced black whenever the delayed de is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            rgb_q <= '0;
        end else if (pix_tick) begin
            hs_q  <= sync_dly.hs;
            vs_q  <= sync_dly.vs;
            rgb_q <= sync_dly.de ? bus.vga_in : '0;
        end
    end

    assign bus.col         = h_cnt;
    assign bus.row         = v_cnt;
    assign bus.active      = active;
    assign bus.pix_tick    = pix_tick;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.r           = pix_r(rgb_q);
    assign bus.g           = pix_g(rgb_q);
    assign bus.b           = pix_b(rgb_q);
    assign bus.frame_start = frame_start;
    assign bus.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Randomized bench for vga_scan_ctrl on a shrunken raster, checked every clock
// against a tick-index reference model.
module tb_vga_scan_ctrl;

    localparam int CLK_DIV = 4;
    localparam int LEAD    = 2;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_scan_ctrl_if bus();

    vga_scan_ctrl #(
        .CLK_DIV (CLK_DIV), .LEAD (LEAD),
        .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m = 0;
    logic [11:0] samp [int];

    task automatic check_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (clk %0d, t=%0t)", tag, act, exp, m, $time);
        end
    endtask

    function automatic int hpos(input int i);
        return i % HT;
    endfunction

    function automatic int vpos(input int i);
        return (i / HT) % VT;
    endfunction

    function automatic bit vis(input int i);
        return (hpos(i) < HV) && (vpos(i) < VV);
    endfunction

    task automatic check_all();
        int n;
        int i;
        int exp_rgb;
        bit exp_hs;
        bit exp_vs;
        n = m / CLK_DIV;
        check_val("col", int'(bus.col), hpos(n));
        check_val("row", int'(bus.row), vpos(n));
        check_val("active", int'(bus.active), int'(vis(n)));
        check_val("pix_tick", int'(bus.pix_tick), int'((m % CLK_DIV) == CLK_DIV - 1));
        check_val("frame_start", int'(bus.frame_start),
                  int'(((m % CLK_DIV) == CLK_DIV - 1) && (((n + 1) % FT) == 0)));
        check_val("frame_cnt", int'(bus.frame_cnt), (n / FT) % 65536);
        // Index 0 after reset is covered by the idle fill, so pins stay idle through tick LEAD.
        if (n <= LEAD) begin
            exp_hs = 1'b1;
            exp_vs = 1'b1;
            exp_rgb = 0;
        end else begin
            i = n - LEAD;
            exp_hs = !((hpos(i) >= HV + HF) && (hpos(i) < HV + HF + HS));
            exp_vs = !((vpos(i) >= VV + VF) && (vpos(i) < VV + VF + VS));
            exp_rgb = vis(i) ? int'(samp[n]) : 0;
        end
        check_val("hs", int'(bus.hs), int'(exp_hs));
        check_val("vs", int'(bus.vs), int'(exp_vs));
        check_val("rgb", int'({bus.r, bus.g, bus.b}), exp_rgb);
    endtask

    task automatic drive();
        int j;
        if ((m % CLK_DIV) == CLK_DIV - 1) begin
            j = m / CLK_DIV + 1 - LEAD;
            case ($urandom_range(0, 2))
                0: bus.vga_in = (j >= 0) ? {4'(hpos(j)), 4'(vpos(j)), 4'hA} : 12'h000;
                1: bus.vga_in = 12'hFFF;
                default: bus.vga_in = 12'($urandom);
            endcase
        end else begin
            bus.vga_in = 12'($urandom);
        end
    endtask

    task automatic run_clks(input int k);
        for (int c = 0; c < k; c++) begin
            @(posedge clk);
            if ((m % CLK_DIV) == CLK_DIV - 1) samp[m / CLK_DIV + 1] = bus.vga_in;
            m++;
            @(negedge clk);
            check_all();
            drive();
        end
    endtask

    initial begin
        int guard;
        bus.vga_in = 12'h000;
        rst_n = 1'b0;
        m = 0;
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        run_clks(3 * FT * CLK_DIV + 200);

        guard = 0;
        while (!(((m / CLK_DIV) % FT) == 2 * HT + 5 && (m % CLK_DIV) == 1) && guard < 4 * FT * CLK_DIV) begin
            run_clks(1);
            guard++;
        end
        check_val("mid_reset_reached", int'(guard < 4 * FT * CLK_DIV), 1);

        // Asynchronous reset mid-line, away from any clock edge
        #2;
        rst_n = 1'b0;
        m = 0;
        samp.delete();
        #1;
        check_all();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        rst_n = 1'b1;

        run_clks(FT * CLK_DIV + 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
